// File: rtl/lfsr_tpg.sv
// Parametrised Fibonacci LFSR test-pattern generator with loadable seed, optional
// all-zero extension, pause, pattern-count limit and start/busy/done handshake.
module lfsr_tpg #(
    parameter int               WIDTH        = 6,
    parameter logic [WIDTH-1:0] TAPS         = 6'b110000,
    parameter logic [WIDTH-1:0] SEED         = 6'b000001,
    parameter int               NUM_PATTERNS = 63,
    localparam int              CW           = $clog2(NUM_PATTERNS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             hold,
    input  logic             complete,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] tv,
    output logic             tv_valid,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    pat_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } fsm_t;

    fsm_t             r_fsm;
    fsm_t             w_fsm_nxt;
    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_seed;
    logic             r_complete;
    logic [CW-1:0]    r_cnt;

    logic             w_fb;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_seed_guard;
    logic [WIDTH-1:0] w_start_seed;
    logic [CW-1:0]    w_cnt_inc;
    logic             w_idle_like;
    logic             w_advance;
    logic             w_last;

    // The zero-run term splices 0 in after 10..0 and leaves it towards 0..01.
    assign w_fb         = (^(r_state & TAPS)) ^ (r_complete & (r_state[WIDTH-2:0] == '0));
    assign w_next       = {r_state[WIDTH-2:0], w_fb};
    assign w_seed_guard = (seed_in == '0) ? SEED : seed_in;
    assign w_start_seed = seed_load ? w_seed_guard : r_seed;
    assign w_cnt_inc    = r_cnt + CW'(1);
    assign w_idle_like  = (r_fsm != S_RUN);
    assign w_advance    = (r_fsm == S_RUN) && !hold;
    assign w_last       = (w_cnt_inc == CW'(NUM_PATTERNS));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE, S_DONE: if (start) w_fsm_nxt = S_RUN;
            S_RUN:          if (w_advance && w_last) w_fsm_nxt = S_DONE;
            default:        w_fsm_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        tv_valid = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_fsm)
            S_RUN: begin
                busy     = 1'b1;
                tv_valid = !hold;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= SEED;
            r_seed     <= SEED;
            r_complete <= 1'b0;
            r_cnt      <= '0;
        end else if (w_idle_like) begin
            if (seed_load) r_seed <= w_seed_guard;
            if (start) begin
                r_state    <= w_start_seed;
                r_complete <= complete;
                r_cnt      <= '0;
            end
        end else if (w_advance) begin
            r_state <= w_next;
            r_cnt   <= w_cnt_inc;
        end
    end

    assign tv      = r_state;
    assign pat_cnt = r_cnt;

endmodule

// File: tb/tb_lfsr_tpg.sv
// Directed bench for lfsr_tpg: default 6-bit build plus an 8-bit build and a
// 64-pattern complete-sequence build sharing the clock and reset.
module tb_lfsr_tpg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start, hold, complete, seed_load;
    logic [5:0] seed_in;
    logic [5:0] tv;
    logic       tv_valid, busy, done;
    logic [5:0] pat_cnt;

    logic       start8;
    logic [7:0] tv8;
    logic       tv_valid8, busy8, done8;
    logic [7:0] pat_cnt8;

    logic       start64;
    logic [5:0] tv64;
    logic       tv_valid64, busy64, done64;
    logic [6:0] pat_cnt64;

    int checks   = 0;
    int failures = 0;
    logic [5:0] vals[$];

    lfsr_tpg u_dut (
        .clk(clk), .reset(reset), .start(start), .hold(hold), .complete(complete),
        .seed_load(seed_load), .seed_in(seed_in), .tv(tv), .tv_valid(tv_valid),
        .busy(busy), .done(done), .pat_cnt(pat_cnt)
    );

    lfsr_tpg #(.WIDTH(8), .TAPS(8'b10111000), .SEED(8'd1), .NUM_PATTERNS(255)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .hold(1'b0), .complete(1'b0),
        .seed_load(1'b0), .seed_in(8'd0), .tv(tv8), .tv_valid(tv_valid8),
        .busy(busy8), .done(done8), .pat_cnt(pat_cnt8)
    );

    lfsr_tpg #(.NUM_PATTERNS(64)) u_dut64 (
        .clk(clk), .reset(reset), .start(start64), .hold(1'b0), .complete(1'b1),
        .seed_load(1'b0), .seed_in(6'd0), .tv(tv64), .tv_valid(tv_valid64),
        .busy(busy64), .done(done64), .pat_cnt(pat_cnt64)
    );

    // Reference next-state for x^6+x+1 with the optional all-zero splice.
    function automatic logic [5:0] nx6(input logic [5:0] s, input logic c);
        logic fb;
        fb = s[5] ^ s[4] ^ (c && (s[4:0] == 5'd0));
        return {s[4:0], fb};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic collect_run(input int budget);
        vals.delete();
        for (int i = 0; i < budget; i++) begin
            if (tv_valid) vals.push_back(tv);
            if (done) break;
            step();
        end
    endtask

    task automatic test_reset();
        checks++; if (tv !== 6'b000001) begin failures++; $display("FAIL rst_tv got=%b exp=000001", tv); end
        checks++; if ({tv_valid, busy, done} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {tv_valid, busy, done}); end
        checks++; if (pat_cnt !== 6'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", pat_cnt); end
    endtask

    task automatic test_sequence();
        logic [5:0] head [7];
        logic       seen [64];
        int         distinct, chain_bad;
        head = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100001, 6'b000011};
        pulse_start();
        collect_run(100);
        checks++; if (vals.size() != 63) begin failures++; $display("FAIL seq_len got=%0d exp=63", vals.size()); end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (vals.size() <= i || vals[i] !== head[i]) begin
                failures++; $display("FAIL seq_head[%0d] got=%b exp=%b", i, (vals.size() > i) ? vals[i] : 6'bx, head[i]);
            end
        end
        foreach (seen[i]) seen[i] = 1'b0;
        distinct  = 0;
        chain_bad = 0;
        foreach (vals[i]) begin
            if (vals[i] != 6'd0 && !seen[vals[i]]) distinct++;
            seen[vals[i]] = 1'b1;
            if (i > 0 && vals[i] !== nx6(vals[i-1], 1'b0)) chain_bad++;
        end
        checks++; if (distinct != 63) begin failures++; $display("FAIL seq_distinct got=%0d exp=63", distinct); end
        checks++; if (chain_bad != 0) begin failures++; $display("FAIL seq_chain bad_steps=%0d exp=0", chain_bad); end
        checks++; if ({done, busy, tv_valid} !== 3'b100) begin failures++; $display("FAIL seq_done_flags got=%b exp=100", {done, busy, tv_valid}); end
        checks++; if (pat_cnt !== 6'd63) begin failures++; $display("FAIL seq_done_cnt got=%0d exp=63", pat_cnt); end
        step();
        checks++; if (tv !== 6'b000001 || done !== 1'b1) begin failures++; $display("FAIL seq_held tv=%b done=%b exp 000001/1", tv, done); end
    endtask

    task automatic test_complete();
        complete = 1'b1;
        pulse_start();
        complete = 1'b0;
        collect_run(100);
        checks++; if (vals.size() != 63) begin failures++; $display("FAIL cpl_len got=%0d exp=63", vals.size()); end
        checks++; if (vals.size() < 63 || vals[62] !== 6'b100000) begin failures++; $display("FAIL cpl_last got=%b exp=100000", (vals.size() >= 63) ? vals[62] : 6'bx); end
        checks++; if (tv !== 6'b000000 || done !== 1'b1) begin failures++; $display("FAIL cpl_zero tv=%b done=%b exp 000000/1", tv, done); end
        pulse_start();
        checks++; if (tv !== 6'b000001 || tv_valid !== 1'b1) begin failures++; $display("FAIL cpl_wrap tv=%b vld=%b exp 000001/1", tv, tv_valid); end
        collect_run(100);
    endtask

    task automatic test_seed_load();
        seed_in   = 6'b101010;
        seed_load = 1'b1;
        step();
        seed_load = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b1) begin failures++; $display("FAIL seed_nostart busy=%b done=%b exp 0/1", busy, done); end
        pulse_start();
        checks++; if (tv !== 6'b101010 || tv_valid !== 1'b1) begin failures++; $display("FAIL seed_first tv=%b vld=%b exp 101010/1", tv, tv_valid); end
        for (int i = 0; i < 3; i++) step();
        seed_in   = 6'b000111;
        seed_load = 1'b1;
        start     = 1'b1;
        step();
        seed_load = 1'b0;
        start     = 1'b0;
        checks++; if (pat_cnt !== 6'd4 || busy !== 1'b1) begin failures++; $display("FAIL seed_run_ignore cnt=%0d busy=%b exp 4/1", pat_cnt, busy); end
        collect_run(100);
        checks++; if (vals.size() != 59 || done !== 1'b1) begin failures++; $display("FAIL seed_run_rest len=%0d done=%b exp 59/1", vals.size(), done); end
        pulse_start();
        checks++; if (tv !== 6'b101010) begin failures++; $display("FAIL seed_kept got=%b exp=101010", tv); end
        collect_run(100);
        seed_in   = 6'b000000;
        seed_load = 1'b1;
        step();
        seed_load = 1'b0;
        pulse_start();
        checks++; if (tv !== 6'b000001) begin failures++; $display("FAIL seed_zero_guard got=%b exp=000001", tv); end
        collect_run(100);
    endtask

    task automatic test_hold();
        int bad;
        bad = 0;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            if (tv_valid !== 1'b1) bad++;
            step();
        end
        checks++; if (tv !== 6'b010000 || pat_cnt !== 6'd4) begin failures++; $display("FAIL hold_pre tv=%b cnt=%0d exp 010000/4", tv, pat_cnt); end
        hold = 1'b1;
        #1;
        checks++; if (tv_valid !== 1'b0) begin failures++; $display("FAIL hold_vld got=%b exp=0", tv_valid); end
        for (int i = 0; i < 3; i++) begin
            step();
            if (tv !== 6'b010000 || pat_cnt !== 6'd4 || tv_valid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL hold_frozen bad_cycles=%0d exp=0", bad); end
        hold = 1'b0;
        #1;
        collect_run(100);
        checks++; if (vals.size() < 2 || vals[0] !== 6'b010000 || vals[1] !== 6'b100001) begin
            failures++; $display("FAIL hold_resume got=%b,%b exp=010000,100001", (vals.size() > 0) ? vals[0] : 6'bx, (vals.size() > 1) ? vals[1] : 6'bx);
        end
        checks++; if (4 + vals.size() != 63 || done !== 1'b1) begin failures++; $display("FAIL hold_total got=%0d done=%b exp 63/1", 4 + vals.size(), done); end
    endtask

    task automatic test_async_reset();
        pulse_start();
        for (int i = 0; i < 20; i++) step();
        checks++; if (pat_cnt !== 6'd20 || busy !== 1'b1) begin failures++; $display("FAIL arst_pre cnt=%0d busy=%b exp 20/1", pat_cnt, busy); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (tv !== 6'b000001 || {busy, done, tv_valid} !== 3'b000 || pat_cnt !== 6'd0) begin
            failures++; $display("FAIL arst_now tv=%b flags=%b cnt=%0d exp 000001/000/0", tv, {busy, done, tv_valid}, pat_cnt);
        end
        #3;
        reset = 1'b1;
        step();
        pulse_start();
        checks++; if (tv !== 6'b000001 || tv_valid !== 1'b1) begin failures++; $display("FAIL arst_restart tv=%b vld=%b exp 000001/1", tv, tv_valid); end
        collect_run(100);
        checks++; if (vals.size() != 63 || done !== 1'b1) begin failures++; $display("FAIL arst_run len=%0d done=%b exp 63/1", vals.size(), done); end
    endtask

    task automatic test_back_to_back();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_pre done=%b exp=1", done); end
        seed_in   = 6'b000111;
        seed_load = 1'b1;
        start     = 1'b1;
        step();
        seed_load = 1'b0;
        start     = 1'b0;
        checks++; if ({done, busy, tv_valid} !== 3'b011 || pat_cnt !== 6'd0) begin failures++; $display("FAIL b2b_flags got=%b cnt=%0d exp 011/0", {done, busy, tv_valid}, pat_cnt); end
        checks++; if (tv !== 6'b000111) begin failures++; $display("FAIL b2b_first got=%b exp=000111", tv); end
        collect_run(100);
        checks++; if (vals.size() != 63 || vals[1] !== 6'b001110) begin failures++; $display("FAIL b2b_run len=%0d second=%b exp 63/001110", vals.size(), (vals.size() > 1) ? vals[1] : 6'bx); end
    endtask

    task automatic test_width8();
        logic seen [256];
        int   nvalid, distinct;
        foreach (seen[i]) seen[i] = 1'b0;
        nvalid   = 0;
        distinct = 0;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (tv_valid8) begin
                nvalid++;
                if (tv8 != 8'd0 && !seen[tv8]) distinct++;
                seen[tv8] = 1'b1;
            end
            if (done8) break;
            step();
        end
        checks++; if (nvalid != 255 || distinct != 255) begin failures++; $display("FAIL w8_distinct valid=%0d distinct=%0d exp 255/255", nvalid, distinct); end
        checks++; if (done8 !== 1'b1 || busy8 !== 1'b0 || pat_cnt8 !== 8'd255) begin failures++; $display("FAIL w8_done done=%b busy=%b cnt=%0d exp 1/0/255", done8, busy8, pat_cnt8); end
    endtask

    task automatic test_full64();
        logic seen [64];
        int   nvalid, distinct;
        foreach (seen[i]) seen[i] = 1'b0;
        nvalid   = 0;
        distinct = 0;
        start64 = 1'b1;
        step();
        start64 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (tv_valid64) begin
                nvalid++;
                if (!seen[tv64]) distinct++;
                seen[tv64] = 1'b1;
            end
            if (done64) break;
            step();
        end
        checks++; if (nvalid != 64 || distinct != 64) begin failures++; $display("FAIL c64_distinct valid=%0d distinct=%0d exp 64/64", nvalid, distinct); end
        checks++; if (done64 !== 1'b1 || busy64 !== 1'b0 || pat_cnt64 !== 7'd64) begin failures++; $display("FAIL c64_done done=%b busy=%b cnt=%0d exp 1/0/64", done64, busy64, pat_cnt64); end
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        hold      = 1'b0;
        complete  = 1'b0;
        seed_load = 1'b0;
        seed_in   = 6'd0;
        start8    = 1'b0;
        start64   = 1'b0;
        #12;
        test_reset();
        reset = 1'b1;
        step();
        test_sequence();
        test_complete();
        test_seed_load();
        test_hold();
        test_async_reset();
        test_back_to_back();
        test_width8();
        test_full64();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfsr_tpg.md
Name: lfsr_tpg

Overview:
- Parametrised pseudo-random test-pattern generator for the BIST datapath; next generation of the fixed 6-bit pattern source.
- Drives the test-vector bus of a circuit-under-test (default: the 6:3 counter).
- Adds generic width and taps, a loadable seed, an optional all-zero ("complete") sequence, a pause input, a pattern-count limit, and start/busy/done handshakes.

Parameters:
WIDTH, 6, register/vector width (>=3)
TAPS, 6'b110000, Fibonacci feedback mask; bit i set means state[i] feeds the XOR; TAPS[WIDTH-1] must be 1
SEED, 6'b000001, reset value of seed register and state; must be nonzero
NUM_PATTERNS, 63, patterns per run (1..2^WIDTH); counter width CW = clog2(NUM_PATTERNS+1)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
start  in  1  begin a run; honoured only in IDLE or DONE
hold  in  1  pause: in RUN, freezes state and counter; tv_valid drops to 0
complete  in  1  1 = 2^WIDTH sequence including all-zero; sampled at start
seed_load  in  1  write seed_in to seed register; honoured only in IDLE or DONE
seed_in  in  WIDTH  new seed value
tv  out  WIDTH  current test vector (equals state register)
tv_valid  out  1  tv is a counted pattern this cycle
busy  out  1  FSM in RUN
done  out  1  run finished; sticky
pat_cnt  out  CW  patterns issued in current/last run

Behaviour:
- Reset (reset=0, asynchronous):
  - state=SEED, seed_reg=SEED, FSM=IDLE.
  - tv=SEED, tv_valid=0, busy=0, done=0, pat_cnt=0.
- Next-state function:
  - fb = XOR-reduce(state & TAPS).
  - If complete_r=1, fb ^= (state[WIDTH-2:0]==0).
  - next = {state[WIDTH-2:0], fb}.
  - Default WIDTH=6, complete=0: period 63. complete=1: period 64.
- FSM states:
  - IDLE: no output changes except seed/start handling.
  - On seed_load=1: seed_reg<=seed_in. If seed_in==0, seed_reg<=SEED instead (lock-up guard).
  - On start=1: state<=seed_reg, complete_r<=complete, pat_cnt<=0, done<=0, go to RUN.
  - start and seed_load in the same cycle: seed_load wins for the seed register, and start loads the *new* value (state<=guarded seed_in).
  - RUN: busy=1. Each cycle with hold=0: tv_valid=1 and presents the current state.
  - In RUN, the clock edge that ends a hold=0 cycle advances state<=next and pat_cnt<=pat_cnt+1.
  - When pat_cnt+1==NUM_PATTERNS on an advance, go to DONE. That last advance still updates state and pat_cnt.
  - hold=1 in RUN: state and pat_cnt frozen, tv_valid=0.
  - start and seed_load are ignored during RUN.
  - DONE: done=1, busy=0, tv_valid=0, tv holds its last state, pat_cnt=NUM_PATTERNS.
  - From DONE, start behaves exactly as in IDLE; seed_load is accepted.
- Latency:
  - start at edge k gives first tv_valid=1 in cycle k+1 with tv=seed.
  - Pattern n (0-based) is presented n cycles later, absent hold.
- Zero-state safety: with complete_r=0, state can never become 0, because the seed is guarded and TAPS includes the MSB.
- Reset mid-run aborts immediately to the reset values; there is no partial done.
- NUM_PATTERNS=1: one tv_valid cycle, then DONE.
- NUM_PATTERNS > period: the sequence wraps and repeats from the seed; this is legal.

Test Plan:
1. Reset, then start=1 for 1 cycle, defaults, complete=0 -> tv sequence 000001, 000010, 000100, 001000, 010000, 100001, 000011, ...
   Across the run: 63 distinct nonzero values, tv_valid high 63 cycles, then done=1, busy=0, pat_cnt=63, tv held.
2. complete=1 at start -> after 100000 the bench sees 000000, then 000001 (next run wraps).
   NUM_PATTERNS=64 build: all 64 values appear exactly once.
3. seed_load with seed_in=101010 in IDLE, then start -> first valid tv=101010.
   seed_load with seed_in=000000 -> first valid tv=000001.
   seed_load during RUN -> seed_reg unchanged.
4. hold=1 for 3 cycles mid-run at tv=010000 -> tv stays 010000, tv_valid=0, pat_cnt frozen.
   After release, next tv=100001; total valid count is still 63.
5. Drive reset=0 asynchronously between clock edges at pattern 20 -> outputs return immediately to tv=000001, busy=0, done=0, pat_cnt=0.
   A new start works normally.
6. From DONE, assert start and seed_load (seed_in=000111) in the same cycle -> done clears, run restarts with first tv=000111.
   Also build WIDTH=8, TAPS=8'b10111000 -> 255 distinct values.
